// File: rtl/spi_burst_slave.sv
// SPI target with selectable CPOL/CPHA, burst writes and one-word-ahead read prefetch.
// Pins are resynchronised to clk; all protocol decisions happen on detected SCLK/SSB edges.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no frame; waiting for a synchronized SSB fall
// S_CMD   | frame open; next sample edge carries the read/write bit
// S_ADDR  | shifting in addrsz address bits
// S_WDATA | shifting in write words, one wr_en strobe per full word
// S_RDATA | shifting out prefetched read words on shift edges
module spi_burst_slave #(
    parameter int addrsz      = 7,
    parameter int payload     = 8,
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SCLK,
    input  logic               SSB,
    input  logic               MOSI,
    output logic               MISO,
    output logic               miso_oe,
    output logic               wr_en,
    output logic [addrsz-1:0]  wr_addr,
    output logic [payload-1:0] wr_data,
    output logic               rd_req,
    output logic [addrsz-1:0]  rd_addr,
    input  logic [payload-1:0] rd_data,
    input  logic               rd_valid,
    output logic               rd_miss,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         word_cnt
);

    localparam bit CPOL        = ((SPI_MODE >> 1) & 1) == 1;
    localparam bit CPHA        = (SPI_MODE & 1) == 1;
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam int MAXW        = (addrsz > payload) ? addrsz : payload;
    localparam int CW          = $clog2(MAXW);
    localparam logic [CW-1:0]     ADDR_LAST = CW'(addrsz - 1);
    localparam logic [CW-1:0]     DATA_LAST = CW'(payload - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [addrsz-1:0] ADDR_ONE  = addrsz'(1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ssb_sync, r_mosi_sync, r_settle;
    logic                   r_sclk_hist, r_ssb_hist, r_armed;

    state_t               r_state;
    logic                 r_cmd, r_load_next, r_pending, r_buf_valid;
    logic [CW-1:0]        r_bit_cnt;
    logic [addrsz-1:0]    r_addr;
    logic [payload-1:0]   r_sh, r_buf;

    logic                 w_sclk, w_ssb, w_mosi, w_sample, w_shift, w_ssb_fall, w_ssb_rise;
    logic                 w_load_hit;
    logic [addrsz-1:0]    w_addr_next;
    logic [payload-1:0]   w_word_next, w_load_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_ssb_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= CPOL;
            r_ssb_hist  <= 1'b1;
            r_settle    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ssb_sync  <= {r_ssb_sync[SYNC_STAGES-2:0], SSB};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_ssb_hist  <= r_ssb_sync[SYNC_STAGES-1];
            r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            // A frame already in flight at reset release must not be joined mid-way:
            // only accept SSB falls once SSB has been seen high on flushed synchronizers.
            if (r_settle[SYNC_STAGES-1] && w_ssb)
                r_armed <= 1'b1;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ssb       = r_ssb_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample    = SAMPLE_RISE ? (w_sclk & ~r_sclk_hist) : (~w_sclk & r_sclk_hist);
    assign w_shift     = SAMPLE_RISE ? (~w_sclk & r_sclk_hist) : (w_sclk & ~r_sclk_hist);
    assign w_ssb_fall  = r_ssb_hist & ~w_ssb;
    assign w_ssb_rise  = ~r_ssb_hist & w_ssb;
    assign w_addr_next = {r_addr[addrsz-2:0], w_mosi};
    assign w_word_next = {r_sh[payload-2:0], w_mosi};
    assign w_load_hit  = r_buf_valid | (r_pending & rd_valid);
    assign w_load_word = r_buf_valid ? r_buf : ((r_pending & rd_valid) ? rd_data : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= 1'b0;
            r_load_next <= 1'b0;
            r_pending   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_sh        <= '0;
            r_buf       <= '0;
            MISO        <= 1'b0;
            miso_oe     <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_miss     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            word_cnt    <= '0;
        end else begin
            wr_en      <= 1'b0;
            rd_req     <= 1'b0;
            rd_miss    <= 1'b0;
            frame_done <= 1'b0;

            if (r_pending && rd_valid) begin
                r_buf       <= rd_data;
                r_buf_valid <= 1'b1;
                r_pending   <= 1'b0;
            end

            if (w_ssb_rise) begin
                frame_done  <= (r_state != S_IDLE);
                r_state     <= S_IDLE;
                busy        <= 1'b0;
                miso_oe     <= 1'b0;
                MISO        <= 1'b0;
                r_pending   <= 1'b0;
                r_buf_valid <= 1'b0;
                r_load_next <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_ssb_fall && r_armed) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= '0;
                            word_cnt  <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_sample) begin
                            r_cmd     <= w_mosi;
                            r_state   <= S_ADDR;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (w_sample) begin
                            r_addr <= w_addr_next;
                            if (r_bit_cnt == ADDR_LAST) begin
                                r_bit_cnt <= '0;
                                if (r_cmd) begin
                                    r_state     <= S_RDATA;
                                    rd_req      <= 1'b1;
                                    rd_addr     <= w_addr_next;
                                    r_pending   <= 1'b1;
                                    r_buf_valid <= 1'b0;
                                    r_load_next <= 1'b1;
                                    miso_oe     <= 1'b1;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sample) begin
                            r_sh <= w_word_next;
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
                                wr_en     <= 1'b1;
                                wr_addr   <= r_addr;
                                wr_data   <= w_word_next;
                                r_addr    <= r_addr + ADDR_ONE;
                                if (word_cnt != 8'hFF)
                                    word_cnt <= word_cnt + 8'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_shift) begin
                            if (r_load_next) begin
                                // Each load consumes the prefetched word and requests the next one.
                                r_sh        <= w_load_word;
                                MISO        <= w_load_word[payload-1];
                                r_load_next <= 1'b0;
                                rd_miss     <= ~w_load_hit;
                                rd_req      <= 1'b1;
                                rd_addr     <= rd_addr + ADDR_ONE;
                                r_pending   <= 1'b1;
                                r_buf_valid <= 1'b0;
                            end else begin
                                r_sh <= {r_sh[payload-2:0], 1'b0};
                                MISO <= r_sh[payload-2];
                            end
                        end
                        if (w_sample) begin
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt   <= '0;
                                r_load_next <= 1'b1;
                                if (word_cnt != 8'hFF)
                                    word_cnt <= word_cnt + 8'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_slave.sv
// Bench for spi_burst_slave: one instance per SPI mode, a bit-level host, a delayed-response
// register bus and a frame-level reference model of expected writes, reads and pulses.
module tb_spi_burst_slave;

    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int HALF = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          sclk [4], ssb [4], mosi [4], rd_valid [4];
    logic [DW-1:0] rd_data [4];
    logic          miso [4], miso_oe [4], wr_en [4], rd_req [4], rd_miss [4], busy [4], frame_done [4];
    logic [AW-1:0] wr_addr [4], rd_addr [4];
    logic [DW-1:0] wr_data [4];
    logic [7:0]    word_cnt [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_burst_slave #(
            .addrsz(AW), .payload(DW), .SPI_MODE(g), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .reset(reset), .SCLK(sclk[g]), .SSB(ssb[g]), .MOSI(mosi[g]),
            .MISO(miso[g]), .miso_oe(miso_oe[g]), .wr_en(wr_en[g]), .wr_addr(wr_addr[g]),
            .wr_data(wr_data[g]), .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
            .rd_valid(rd_valid[g]), .rd_miss(rd_miss[g]), .busy(busy[g]),
            .frame_done(frame_done[g]), .word_cnt(word_cnt[g])
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem [128];
    bit          bus_en [4];
    logic [16:0] wlog [$];
    logic [8:0]  rqlog [$];
    int          miss_cnt = 0;
    int          fd_cnt   = 0;
    bit          tx_bits [$];
    logic [7:0]  tx_words [$];
    logic        rx_miso [$];
    logic        rx_oe [$];

    // Event log of every strobe, checked later against the frame model
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (wr_en[m])      wlog.push_back({2'(m), wr_addr[m], wr_data[m]});
            if (rd_req[m])     rqlog.push_back({2'(m), rd_addr[m]});
            if (rd_miss[m])    miss_cnt++;
            if (frame_done[m]) fd_cnt++;
        end
    end

    // Register bus: answers each rd_req a few cycles later when enabled
    int         rv_cnt [4];
    logic [6:0] rv_addr [4];
    initial begin
        for (int m = 0; m < 4; m++) begin
            rd_valid[m] = 1'b0; rd_data[m] = '0; rv_cnt[m] = 0; rv_addr[m] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int m = 0; m < 4; m++) begin
                rd_valid[m] = 1'b0;
                if (rv_cnt[m] > 0) begin
                    rv_cnt[m]--;
                    if (rv_cnt[m] == 0) begin
                        rd_valid[m] = 1'b1;
                        rd_data[m]  = mem[rv_addr[m]];
                    end
                end
                if (rd_req[m] && bus_en[m]) begin
                    rv_cnt[m]  = 2;
                    rv_addr[m] = rd_addr[m];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half_wait();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic build(input bit cmd, input logic [6:0] addr, input int trunc);
        tx_bits.delete();
        tx_bits.push_back(cmd);
        for (int i = 6; i >= 0; i--) tx_bits.push_back(addr[i]);
        foreach (tx_words[w])
            for (int b = 7; b >= 0; b--) tx_bits.push_back(tx_words[w][b]);
        for (int i = 0; i < trunc; i++) void'(tx_bits.pop_back());
    endtask

    task automatic spi_run(input int m, input int reset_at);
        bit cpol, cpha;
        int n;
        cpol = m[1];
        cpha = m[0];
        n    = tx_bits.size();
        rx_miso.delete();
        rx_oe.delete();
        ssb[m] = 1'b0;
        half_wait();
        for (int i = 0; i < n; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
            end
            if (!cpha) begin
                mosi[m] = tx_bits[i];
                half_wait();
                rx_miso.push_back(miso[m]); rx_oe.push_back(miso_oe[m]);
                sclk[m] = ~cpol;
                half_wait();
                if (i != n - 1) sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = tx_bits[i];
                half_wait();
                rx_miso.push_back(miso[m]); rx_oe.push_back(miso_oe[m]);
                sclk[m] = cpol;
                half_wait();
            end
        end
        ssb[m] = 1'b1;
        half_wait();
        sclk[m] = cpol;
        mosi[m] = 1'b0;
        half_wait();
        half_wait();
    endtask

    task automatic do_write(input int m, input logic [6:0] addr, input int trunc, input string tag);
        int w0, fd0, nfull;
        w0    = wlog.size();
        fd0   = fd_cnt;
        nfull = tx_words.size() - ((trunc > 0) ? 1 : 0);
        build(1'b0, addr, trunc);
        spi_run(m, -1);
        check({tag, "_nwr"}, 64'(wlog.size() - w0), 64'(nfull));
        for (int i = 0; i < nfull; i++)
            if (w0 + i < wlog.size())
                check($sformatf("%s_wr%0d", tag, i), 64'(wlog[w0 + i]),
                      64'({2'(m), 7'((int'(addr) + i) % 128), tx_words[i]}));
        check({tag, "_wcnt"}, 64'(word_cnt[m]), 64'(nfull));
        check({tag, "_fdone"}, 64'(fd_cnt - fd0), 64'd1);
        check({tag, "_busy"}, 64'(busy[m]), 64'd0);
    endtask

    task automatic do_read(input int m, input logic [6:0] addr, input int nw, input string tag);
        int r0, mi0, fd0;
        logic [63:0] got, exp, hdr, oe_all;
        r0  = rqlog.size();
        mi0 = miss_cnt;
        fd0 = fd_cnt;
        tx_words.delete();
        for (int i = 0; i < nw; i++) tx_words.push_back(8'h00);
        build(1'b1, addr, 0);
        spi_run(m, -1);
        got = '0; exp = '0; hdr = '0; oe_all = 64'd1;
        for (int i = 0; i < 8; i++) hdr = hdr | 64'(rx_oe[i]) | 64'(rx_miso[i]);
        for (int i = 8; i < rx_miso.size(); i++) begin
            got    = {got[62:0], rx_miso[i]};
            oe_all = oe_all & 64'(rx_oe[i]);
        end
        for (int i = 0; i < nw; i++)
            exp = (exp << 8) | (bus_en[m] ? 64'(mem[(int'(addr) + i) % 128]) : 64'd0);
        check({tag, "_hdr_quiet"}, hdr, 64'd0);
        check({tag, "_oe_data"}, oe_all, 64'd1);
        check({tag, "_miso"}, got, exp);
        check({tag, "_nreq"}, 64'(rqlog.size() - r0), 64'(nw + 1));
        for (int i = 0; i <= nw; i++)
            if (r0 + i < rqlog.size())
                check($sformatf("%s_req%0d", tag, i), 64'(rqlog[r0 + i]),
                      64'({2'(m), 7'((int'(addr) + i) % 128)}));
        check({tag, "_miss"}, 64'(miss_cnt - mi0), bus_en[m] ? 64'd0 : 64'(nw));
        check({tag, "_wcnt"}, 64'(word_cnt[m]), 64'(nw));
        check({tag, "_fdone"}, 64'(fd_cnt - fd0), 64'd1);
        check({tag, "_idle_out"}, 64'({miso_oe[m], miso[m]}), 64'd0);
    endtask

    initial begin
        int          m, nw, w0, fd0, r0;
        logic [6:0]  a;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = i[1]; ssb[i] = 1'b1; mosi[i] = 1'b0; bus_en[i] = 1'b0;
        end
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hC3;
        mem[6] = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_m%0d", i),
                  64'({miso[i], miso_oe[i], wr_en[i], rd_req[i], rd_miss[i], busy[i], frame_done[i],
                       wr_addr[i], wr_data[i], rd_addr[i], word_cnt[i]}), 64'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        tx_words = '{8'hA5};
        do_write(0, 7'h12, 0, "m0_single");

        tx_words = '{8'h11, 8'h22, 8'h33};
        do_write(3, 7'h7E, 0, "m3_wrap");

        bus_en[1] = 1'b1;
        do_read(1, 7'h05, 2, "m1_read");

        bus_en[2] = 1'b0;
        do_read(2, 7'($urandom), 1, "m2_miss");

        tx_words = '{8'h96, 8'h5B};
        do_write(0, 7'h30, 3, "m0_partial");

        // Reset lands inside the address phase; the rest of that frame must be ignored
        tx_words = '{8'hFF};
        w0  = wlog.size();
        fd0 = fd_cnt;
        r0  = rqlog.size();
        build(1'b0, 7'h55, 0);
        spi_run(0, 3);
        check("rst_abort_nwr", 64'(wlog.size() - w0), 64'd0);
        check("rst_abort_fdone", 64'(fd_cnt - fd0), 64'd0);
        check("rst_abort_nreq", 64'(rqlog.size() - r0), 64'd0);
        check("rst_abort_state", 64'({busy[0], word_cnt[0]}), 64'd0);
        tx_words = '{8'h5A};
        do_write(0, 7'h01, 0, "rst_clean");

        for (int k = 0; k < 3; k++) begin
            m  = int'($urandom_range(3));
            a  = 7'($urandom);
            nw = int'($urandom_range(1, 3));
            tx_words.delete();
            for (int i = 0; i < nw; i++) tx_words.push_back(8'($urandom));
            do_write(m, a, 0, $sformatf("rnd_wr%0d_m%0d", k, m));
        end
        for (int k = 0; k < 2; k++) begin
            m  = int'($urandom_range(3));
            a  = 7'($urandom);
            nw = int'($urandom_range(1, 3));
            bus_en[m] = 1'b1;
            do_read(m, a, nw, $sformatf("rnd_rd%0d_m%0d", k, m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
